fifo_read_arbiter: RTL and testbench

Round-robin arbiter sharing the single read port of the async FIFO among `NREQ` consumers in the read clock domain. It drives the FIFO's `rinc` from the `rempty` it receives and returns popped data, tagged with the owner's index, to the granted consumer. Each grant is capped at `BURST` pops so one consumer cannot monopolise the FIFO. It sits between the FIFO read-side handler/memory and the downstream consumers.

---
 rtl/fifo_arb_pkg.sv | 26 ++
 rtl/rr_pick.sv | 38 +++
 rtl/fifo_read_arbiter.sv | 138 +++++++++++++
 tb/tb_fifo_read_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and width helpers for the FIFO read-port arbiter.
//   arb_state_e : arbiter FSM state encoding
//   idx_w()     : width of a consumer index for n consumers
//   cnt_w()     : width of a pop counter that can hold 0..b
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF  = 4;
    localparam int BURST_DEF = 4;
    localparam int IDX_W_DEF = $clog2(NREQ_DEF);
    localparam int CNT_W_DEF = $clog2(BURST_DEF + 1);

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int b);
        return (b > 0) ? $clog2(b + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first requester found when
// scanning upward from ptr, wrapping modulo NREQ.
// Ports:
//   req [NREQ] : request vector
//   ptr [IW]   : scan start index (always < NREQ)
//   any        : at least one request is high
//   idx [IW]   : selected index, 0 when any is low
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest offset back to the nearest so that the last
    // hit written is the first one in round-robin order.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_read_arbiter.sv
// fifo_read_arbiter
// Round-robin arbiter sharing the async FIFO read port among NREQ consumers.
// Each grant is capped at BURST pops; handover between owners is bubble-free.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no owner; a pick is loaded as soon as any req is high
//   GRANT | owner holds the read port; pops while req[owner] & ~rempty
//
// Ports:
//   rclk, rrst     : read clock, synchronous active-high reset
//   req [NREQ]     : consumer i wants a word and can accept it this cycle
//   rempty, rdata  : FIFO empty flag and head word
//   rinc           : pop strobe to the FIFO
//   gnt [NREQ]     : one-hot current owner or zero
//   dvalid, dout   : delivered word strobe (== rinc) and word (== rdata)
//   did            : owner index tagging dout
//   busy           : an owner is held
module fifo_read_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic [NREQ-1:0]          req,
    input  logic                     rempty,
    input  logic [DW-1:0]            rdata,
    output logic                     rinc,
    output logic [NREQ-1:0]          gnt,
    output logic                     dvalid,
    output logic [DW-1:0]            dout,
    output logic [idx_w(NREQ)-1:0]   did,
    output logic                     busy
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = cnt_w(BURST);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    arb_state_e    state, state_nxt;
    logic [IW-1:0] owner, owner_nxt;
    logic [IW-1:0] ptr, ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    logic [IW-1:0] owner_inc;
    logic [IW-1:0] pick_ptr;
    logic          pick_any;
    logic [IW-1:0] pick_idx;
    logic          in_grant;
    logic          req_own;
    logic          pop;
    logic          release_gnt;

    assign in_grant  = (state == GRANT);
    assign owner_inc = (owner == IDX_LAST) ? '0 : owner + 1'b1;

    // One picker serves both paths: from IDLE it scans from ptr, on release
    // it scans from owner+1, which leaves the old owner last in line so it
    // only wins when it is the sole requester.
    assign pick_ptr = in_grant ? owner_inc : ptr;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req  (req),
        .ptr  (pick_ptr),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    assign req_own = req[owner];

    // Reset gates the pop combinationally so no word is lost while rrst is
    // high, even though the state only clears at the next edge.
    assign pop = in_grant & req_own & ~rempty & ~rrst;

    // Empty alone never releases: the owner keeps the port and the count.
    assign release_gnt = in_grant & ((pop & (cnt == CNT_LAST)) | ~req_own);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt = GRANT;
                    owner_nxt = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (release_gnt) begin
                    ptr_nxt = owner_inc;
                    cnt_nxt = '0;
                    if (pick_any) begin
                        owner_nxt = pick_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (pop) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign rinc   = pop;
    assign dvalid = pop;
    assign dout   = rdata;
    assign did    = in_grant ? owner : '0;
    assign busy   = in_grant;
    assign gnt    = in_grant ? (NREQ'(1) << owner) : '0;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
module tb_fifo_read_arbiter;

    logic       rclk = 1'b0;
    logic       rrst;
    logic [3:0] req, req2;
    logic       rempty, rempty2;
    logic [7:0] rdata, rdata2;
    logic       rinc, rinc2, dvalid, dvalid2, busy, busy2;
    logic [3:0] gnt, gnt2;
    logic [7:0] dout, dout2;
    logic [1:0] did, did2;

    int tests = 0;
    int fails = 0;

    logic [7:0] head, head2;
    int         avail, avail2;
    logic [8:0] s_obs;
    logic [7:0] s_dout;

    always #5 rclk = ~rclk;

    fifo_read_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
        .rclk(rclk), .rrst(rrst), .req(req), .rempty(rempty), .rdata(rdata),
        .rinc(rinc), .gnt(gnt), .dvalid(dvalid), .dout(dout), .did(did), .busy(busy)
    );

    fifo_read_arbiter #(.NREQ(4), .DW(8), .BURST(2)) dut2 (
        .rclk(rclk), .rrst(rrst), .req(req2), .rempty(rempty2), .rdata(rdata2),
        .rinc(rinc2), .gnt(gnt2), .dvalid(dvalid2), .dout(dout2), .did(did2), .busy(busy2)
    );

    // One cycle on dut: drive at negedge, sample, then let the FIFO model pop.
    task automatic tick(input logic [3:0] r, input logic stall, input logic rst);
        @(negedge rclk);
        rrst   = rst;
        req    = r;
        rempty = stall || (avail == 0);
        rdata  = head;
        #1;
        s_obs  = {rinc, dvalid, gnt, did, busy};
        s_dout = dout;
        @(posedge rclk);
        if (s_obs[8]) begin
            head  = head + 8'd1;
            avail = avail - 1;
        end
    endtask

    task automatic tick2(input logic [3:0] r);
        @(negedge rclk);
        rrst    = 1'b0;
        req2    = r;
        rempty2 = (avail2 == 0);
        rdata2  = head2;
        #1;
        s_obs  = {rinc2, dvalid2, gnt2, did2, busy2};
        s_dout = dout2;
        @(posedge rclk);
        if (s_obs[8]) begin
            head2  = head2 + 8'd1;
            avail2 = avail2 - 1;
        end
    endtask

    task automatic do_reset();
        @(negedge rclk);
        rrst    = 1'b1;
        req     = '0;
        req2    = '0;
        rempty  = 1'b1;
        rempty2 = 1'b1;
        repeat (2) @(posedge rclk);
    endtask

    task automatic test_reset();
        do_reset();
        tick(4'b1111, 1'b0, 1'b1);
        tests++;
        if (s_obs !== 9'b0) begin
            fails++;
            $display("FAIL reset_hold: obs=%b expected=%b", s_obs, 9'b0);
        end
        tick(4'b0000, 1'b0, 1'b0);
        tests++;
        if (s_obs !== 9'b0) begin
            fails++;
            $display("FAIL reset_state: obs=%b expected=%b", s_obs, 9'b0);
        end
    endtask

    task automatic test_single();
        logic [3:0] rq[8];
        logic [8:0] ex[8];
        do_reset();
        head  = 8'h10;
        avail = 3;
        rq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        ex = '{9'b0_0_0000_00_0, 9'b1_1_0010_01_1, 9'b1_1_0010_01_1, 9'b1_1_0010_01_1,
               9'b0_0_0010_01_1, 9'b0_0_0010_01_1, 9'b0_0_0010_01_1, 9'b0_0_0000_00_0};
        for (int i = 0; i < 8; i++) begin
            tick(rq[i], 1'b0, 1'b0);
            tests++;
            if (s_obs !== ex[i]) begin
                fails++;
                $display("FAIL single c%0d: obs=%b expected=%b", i, s_obs, ex[i]);
            end
            if (i >= 1 && i <= 3) begin
                tests++;
                if (s_dout !== 8'(16 + i - 1)) begin
                    fails++;
                    $display("FAIL single_dout c%0d: got=%h expected=%h", i, s_dout, 8'(16 + i - 1));
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [8:0] ex;
        int d;
        do_reset();
        head  = 8'h00;
        avail = 1000;
        tick(4'b1111, 1'b0, 1'b0);
        tests++;
        if (s_obs !== 9'b0) begin
            fails++;
            $display("FAIL rr_first: obs=%b expected=%b", s_obs, 9'b0);
        end
        for (int k = 0; k < 20; k++) begin
            tick(4'b1111, 1'b0, 1'b0);
            d  = (k / 4) % 4;
            ex = {1'b1, 1'b1, 4'(1 << d), 2'(d), 1'b1};
            tests++;
            if (s_obs !== ex) begin
                fails++;
                $display("FAIL rr k%0d: obs=%b expected=%b", k, s_obs, ex);
            end
            tests++;
            if (s_dout !== 8'(k)) begin
                fails++;
                $display("FAIL rr_dout k%0d: got=%h expected=%h", k, s_dout, 8'(k));
            end
        end
        tick(4'b0000, 1'b0, 1'b0);
        tests++;
        if (s_obs !== 9'b0_0_0010_01_1) begin
            fails++;
            $display("FAIL rr_end: obs=%b expected=%b", s_obs, 9'b0_0_0010_01_1);
        end
    endtask

    task automatic test_drop();
        logic [3:0] rq[5];
        logic [8:0] ex[5];
        do_reset();
        avail = 1000;
        rq = '{4'b0100, 4'b1101, 4'b1001, 4'b1001, 4'b0000};
        ex = '{9'b0_0_0000_00_0, 9'b1_1_0100_10_1, 9'b0_0_0100_10_1,
               9'b1_1_1000_11_1, 9'b0_0_1000_11_1};
        for (int i = 0; i < 5; i++) begin
            tick(rq[i], 1'b0, 1'b0);
            tests++;
            if (s_obs !== ex[i]) begin
                fails++;
                $display("FAIL drop c%0d: obs=%b expected=%b", i, s_obs, ex[i]);
            end
        end
    endtask

    task automatic test_empty_toggle();
        logic [8:0] ex;
        int d;
        do_reset();
        avail = 1000;
        tick(4'b0011, 1'b0, 1'b0);
        tests++;
        if (s_obs !== 9'b0) begin
            fails++;
            $display("FAIL empty_first: obs=%b expected=%b", s_obs, 9'b0);
        end
        for (int k = 0; k < 10; k++) begin
            tick(4'b0011, (k % 2) == 0, 1'b0);
            d  = (k <= 7) ? 0 : 1;
            ex = {k[0], k[0], 4'(1 << d), 2'(d), 1'b1};
            tests++;
            if (s_obs !== ex) begin
                fails++;
                $display("FAIL empty k%0d: obs=%b expected=%b", k, s_obs, ex);
            end
        end
        tick(4'b0000, 1'b0, 1'b0);
        tests++;
        if (s_obs !== 9'b0_0_0010_01_1) begin
            fails++;
            $display("FAIL empty_end: obs=%b expected=%b", s_obs, 9'b0_0_0010_01_1);
        end
    endtask

    // Entered from IDLE with ptr=2 left by the previous test.
    task automatic test_reset_mid();
        logic [3:0] rq[8];
        logic       rs[8];
        logic [8:0] ex[8];
        avail = 1000;
        rq = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011, 4'b0000};
        rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ex = '{9'b0_0_0000_00_0, 9'b1_1_0001_00_1, 9'b0_0_0001_00_1, 9'b1_1_0010_01_1,
               9'b0_0_0010_01_1, 9'b0_0_0000_00_0, 9'b1_1_0001_00_1, 9'b0_0_0001_00_1};
        for (int i = 0; i < 8; i++) begin
            tick(rq[i], 1'b0, rs[i]);
            tests++;
            if (s_obs !== ex[i]) begin
                fails++;
                $display("FAIL reset_mid c%0d: obs=%b expected=%b", i, s_obs, ex[i]);
            end
        end
    endtask

    task automatic test_burst2();
        logic [8:0] ex;
        int d;
        do_reset();
        head2  = 8'h40;
        avail2 = 1000;
        tick2(4'b0010);
        tests++;
        if (s_obs !== 9'b0) begin
            fails++;
            $display("FAIL b2_first: obs=%b expected=%b", s_obs, 9'b0);
        end
        for (int k = 0; k < 8; k++) begin
            tick2(4'b0010);
            tests++;
            if (s_obs !== 9'b1_1_0010_01_1 || s_dout !== 8'(64 + k)) begin
                fails++;
                $display("FAIL b2_sole k%0d: obs=%b dout=%h expected=%b dout=%h",
                         k, s_obs, s_dout, 9'b1_1_0010_01_1, 8'(64 + k));
            end
        end
        tick2(4'b0000);
        tests++;
        if (s_obs !== 9'b0_0_0010_01_1) begin
            fails++;
            $display("FAIL b2_drop: obs=%b expected=%b", s_obs, 9'b0_0_0010_01_1);
        end
        tick2(4'b0011);
        tests++;
        if (s_obs !== 9'b0) begin
            fails++;
            $display("FAIL b2_idle: obs=%b expected=%b", s_obs, 9'b0);
        end
        for (int k = 0; k < 6; k++) begin
            tick2(4'b0011);
            d  = (k / 2) % 2;
            ex = {1'b1, 1'b1, 4'(1 << d), 2'(d), 1'b1};
            tests++;
            if (s_obs !== ex) begin
                fails++;
                $display("FAIL b2_pair k%0d: obs=%b expected=%b", k, s_obs, ex);
            end
        end
    endtask

    initial begin
        rrst    = 1'b1;
        req     = '0;
        req2    = '0;
        rempty  = 1'b1;
        rempty2 = 1'b1;
        rdata   = '0;
        rdata2  = '0;
        head    = '0;
        head2   = '0;
        avail   = 0;
        avail2  = 0;
        s_obs   = '0;
        s_dout  = '0;

        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_empty_toggle();
        test_reset_mid();
        test_burst2();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
